cfg_cmd_ctrl: RTL

CFG_CMD_CTRL -- requirements
Module: cfg_cmd_ctrl

---
 rtl/cfg_cmd_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cfg_cmd_ctrl.sv
// cfg_cmd_ctrl: hands command bytes written by the config register block to a
// firmware CPU. The CPU acknowledges a command, optionally returns two result
// words, then signals completion. Outstanding commands are bounded by a
// timeout, and a dropped second command is recorded as a sticky overrun.
module cfg_cmd_ctrl #(
    parameter logic [23:0] TIMEOUT = 24'd6_250_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_request,
    input  logic [7:0]  cmd,
    output logic        cpu_ready,
    output logic        cpu_busy,
    output logic        cmd_error,
    output logic [1:0]  data_write,
    output logic [31:0] wdata,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_EXEC    = 2'd2
    } state_e;

    // CPU access as seen in the request cycle
    typedef struct packed {
        logic        req;
        logic        write;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } cpu_req_t;

    // CPU access completion, registered one cycle after the request
    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
    } cpu_rsp_t;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_DATA0 = 2'd1;
    localparam logic [1:0] ADDR_DATA1 = 2'd2;
    localparam logic [1:0] ADDR_DONE  = 2'd3;

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] timer_q, timer_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic        error_q, error_d;
    logic        ready_q, ready_d;
    logic [1:0]  dw_q, dw_d;
    logic [31:0] wdata_q, wdata_d;
    cpu_rsp_t    rsp_q, rsp_d;

    cpu_req_t    creq;
    logic        active;
    logic        rd_ctrl;
    logic        wr_ack;
    logic        wr_data;
    logic        wr_done;
    logic        done;
    logic        expired;
    logic        accept;

    assign creq = '{req: cpu_req, write: cpu_write, addr: cpu_addr, wdata: cpu_wdata};

    // Decode of the current cycle's events shared by next-state and datapath
    always_comb begin
        active  = (state_q != ST_IDLE);
        rd_ctrl = creq.req && !creq.write && (creq.addr == ADDR_CTRL);
        wr_ack  = creq.req && creq.write && (creq.addr == ADDR_CTRL);
        wr_data = creq.req && creq.write &&
                  ((creq.addr == ADDR_DATA0) || (creq.addr == ADDR_DATA1));
        wr_done = creq.req && creq.write && (creq.addr == ADDR_DONE);
        // A completion write only means DONE while a command is outstanding
        done    = wr_done && active;
        // DONE in the same cycle as the last timer tick takes precedence
        expired = active && (timer_q == (TIMEOUT - 24'd1)) && !done;
        // New command taken when idle, or when this cycle's DONE frees the slot
        accept  = cmd_request && (!active || done);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_request) state_d = ST_PENDING;
            end
            ST_PENDING, ST_EXEC: begin
                if (done)
                    state_d = cmd_request ? ST_PENDING : ST_IDLE;
                else if (expired)
                    state_d = ST_IDLE;
                else if ((state_q == ST_PENDING) && wr_ack)
                    state_d = ST_EXEC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: command latch, timer, sticky flags, CPU response
    always_comb begin
        cmd_d     = accept ? cmd : cmd_q;
        timer_d   = timer_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        error_d   = error_q;
        ready_d   = ready_q;
        dw_d      = 2'b00;
        wdata_d   = 32'd0;
        rsp_d     = '{ack: creq.req, rdata: 32'd0};

        if (accept)      timer_d = 24'd0;
        else if (active) timer_d = timer_q + 24'd1;

        // Status read reports the pre-clear flags, then clears them; a new
        // event in the same cycle is set after the clear so it is not lost
        if (rd_ctrl) begin
            rsp_d.rdata = {(state_q == ST_PENDING), active, overrun_q, timeout_q,
                           20'd0, cmd_q};
            overrun_d   = 1'b0;
            timeout_d   = 1'b0;
        end
        if (cmd_request && active && !done) overrun_d = 1'b1;
        if (expired) timeout_d = 1'b1;

        if (accept)       error_d = 1'b0;
        else if (done)    error_d = creq.wdata[0];
        else if (expired) error_d = 1'b1;

        // Ready handshake bits act in every state; set beats clear
        if (wr_done) begin
            if (creq.wdata[31])      ready_d = 1'b1;
            else if (creq.wdata[30]) ready_d = 1'b0;
        end

        // Result words only strobe out while the command is executing
        if (wr_data && (state_q == ST_EXEC)) begin
            dw_d    = (creq.addr == ADDR_DATA0) ? 2'b01 : 2'b10;
            wdata_d = creq.wdata;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= 8'd0;
            timer_q   <= 24'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
            dw_q      <= 2'b00;
            wdata_q   <= 32'd0;
            rsp_q     <= '0;
        end else begin
            cmd_q     <= cmd_d;
            timer_q   <= timer_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
            ready_q   <= ready_d;
            dw_q      <= dw_d;
            wdata_q   <= wdata_d;
            rsp_q     <= rsp_d;
        end
    end

    // Outputs: busy/irq decode straight from state so reset clears them at once
    always_comb begin
        cpu_busy   = (state_q != ST_IDLE);
        irq        = (state_q == ST_PENDING);
        cpu_ready  = ready_q;
        cmd_error  = error_q;
        data_write = dw_q;
        wdata      = wdata_q;
        cpu_ack    = rsp_q.ack;
        cpu_rdata  = rsp_q.rdata;
    end

endmodule
